// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: fetches whole cache lines over AXI read bursts into an
// instruction FIFO, handling redirects, bus errors and a halt-on-error state.
module ifetch_prefetch #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ID_WIDTH   = 13,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned FIFO_DEPTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] entry,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  instr_valid,
   output logic [31:0]           instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  instr_ready,
   output logic                  fetch_error,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam int unsigned IPB       = DATA_WIDTH / 32;
   localparam int unsigned IPL       = BURST_LEN * IPB;
   localparam int unsigned BB        = DATA_WIDTH / 8;
   localparam int unsigned LB        = BURST_LEN * BB;
   localparam int unsigned SIZE_LOG2 = $clog2(BB);
   localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W     = PTR_W + 1;
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LB - 1);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_DRAIN, S_HALT} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic [ADDR_WIDTH-1:0] r_beat_addr;
   logic                  r_drain_pend;
   logic                  r_err_line;
   logic                  r_fetch_error;
   logic [PTR_W-1:0]      r_rptr;
   logic [PTR_W-1:0]      r_wptr;
   logic [CNT_W-1:0]      r_count;
   logic [31:0]           r_mem_instr [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] r_mem_pc    [FIFO_DEPTH];

   logic                  w_arvalid;
   logic                  w_rready;
   logic                  w_beat;
   logic                  w_beat_err;
   logic                  w_push_ok;
   logic                  w_pop;
   logic                  w_empty;
   logic [CNT_W-1:0]      w_free;
   logic [CNT_W-1:0]      w_push_cnt;
   logic [ADDR_WIDTH-1:0] w_lane_pc    [IPB];
   logic [IPB-1:0]        w_lane_en;
   logic [PTR_W-1:0]      w_lane_waddr [IPB];
   logic                  w_unused;

   assign w_unused    = ^m_axi_rid;
   assign w_beat      = m_axi_rvalid && w_rready;
   assign w_beat_err  = w_beat && (m_axi_rresp != 2'b00);
   // Beats on a redirect cycle, an error beat, or after an error are never enqueued.
   assign w_push_ok   = (r_state == S_DATA) && w_beat && !w_beat_err && !r_err_line && !redirect_valid;
   assign w_empty     = (r_count == '0);
   assign w_free      = CNT_W'(FIFO_DEPTH) - r_count;
   assign instr_valid = !w_empty && !redirect_valid;
   assign w_pop       = instr_valid && instr_ready;

   assign instr         = r_mem_instr[r_rptr];
   assign instr_pc      = r_mem_pc[r_rptr];
   assign fetch_error   = r_fetch_error;
   assign m_axi_arid    = '0;
   assign m_axi_araddr  = r_araddr;
   assign m_axi_arlen   = 8'(BURST_LEN - 1);
   assign m_axi_arsize  = 3'(SIZE_LOG2);
   assign m_axi_arburst = 2'b01;
   assign m_axi_arprot  = 3'b100;
   assign m_axi_arvalid = w_arvalid;
   assign m_axi_rready  = w_rready;

   // Per-lane PC of the current beat, lane enables (PC >= fetch_pc) and packed FIFO slots.
   always_comb begin
      w_push_cnt = '0;
      for (int j = 0; j < IPB; j++) begin
         w_lane_pc[j]    = r_beat_addr + ADDR_WIDTH'(4 * j);
         w_lane_en[j]    = w_push_ok && (w_lane_pc[j] >= r_fetch_pc);
         w_lane_waddr[j] = r_wptr + PTR_W'(w_push_cnt);
         w_push_cnt      = w_push_cnt + CNT_W'(w_lane_en[j]);
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and AXI handshake strobes.
   always_comb begin
      w_next    = r_state;
      w_arvalid = 1'b0;
      w_rready  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!redirect_valid && (w_free >= CNT_W'(IPL))) w_next = S_REQ;
         end
         S_REQ: begin
            w_arvalid = 1'b1;
            if (m_axi_arready) w_next = (r_drain_pend || redirect_valid) ? S_DRAIN : S_DATA;
         end
         S_DATA: begin
            w_rready = 1'b1;
            if (w_beat && m_axi_rlast)            w_next = (w_beat_err || r_err_line) ? S_HALT : S_IDLE;
            else if (w_beat_err || redirect_valid) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            w_rready = 1'b1;
            if (w_beat && m_axi_rlast) w_next = r_err_line ? S_HALT : S_IDLE;
         end
         S_HALT: begin
            if (redirect_valid) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Fetch PC, request address, error tracking and FIFO pointers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc    <= entry;
         r_araddr      <= '0;
         r_beat_addr   <= '0;
         r_drain_pend  <= 1'b0;
         r_err_line    <= 1'b0;
         r_fetch_error <= 1'b0;
         r_rptr        <= '0;
         r_wptr        <= '0;
         r_count       <= '0;
      end else begin
         if ((r_state == S_IDLE) && (w_next == S_REQ)) begin
            r_araddr     <= r_fetch_pc & LINE_MASK;
            r_beat_addr  <= r_fetch_pc & LINE_MASK;
            r_err_line   <= 1'b0;
            r_drain_pend <= 1'b0;
         end
         if ((r_state == S_REQ) && redirect_valid) r_drain_pend <= 1'b1;
         if (w_beat) r_beat_addr <= r_beat_addr + ADDR_WIDTH'(BB);
         if ((r_state == S_DATA) && w_beat_err) begin
            r_err_line    <= 1'b1;
            r_fetch_error <= 1'b1;
         end
         if ((r_state == S_HALT) && redirect_valid) r_fetch_error <= 1'b0;

         if (redirect_valid)                                   r_fetch_pc <= redirect_pc;
         else if ((r_state == S_DATA) && w_beat && m_axi_rlast) r_fetch_pc <= r_araddr + ADDR_WIDTH'(LB);

         if (redirect_valid) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
         end else begin
            r_rptr  <= r_rptr + PTR_W'(w_pop);
            r_wptr  <= r_wptr + PTR_W'(w_push_cnt);
            r_count <= r_count + w_push_cnt - CNT_W'(w_pop);
         end
      end
   end

   // FIFO storage: each enabled lane lands in its packed slot.
   always_ff @(posedge clk) begin
      for (int j = 0; j < IPB; j++) begin
         if (w_lane_en[j]) begin
            r_mem_instr[w_lane_waddr[j]] <= m_axi_rdata[32*j +: 32];
            r_mem_pc[w_lane_waddr[j]]    <= w_lane_pc[j];
         end
      end
   end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: behavioural AXI slave plus a
// stream-level model (sequential PCs from the last redirect, line-granular fetch cursor).
module tb_ifetch_prefetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] entry;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        instr_ready;
   logic        fetch_error;
   logic [12:0] m_axi_arid;
   logic [63:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [12:0] m_axi_rid;
   logic [63:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast;
   logic        m_axi_rvalid;
   logic        m_axi_rready;

   always #5 clk = ~clk;

   ifetch_prefetch dut (
      .clk(clk), .reset(reset), .entry(entry),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
      .fetch_error(fetch_error),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Stimulus policies
   int p_arready, p_rvalid, p_ready, p_redir, pop_budget;
   int redir_at_beat;
   logic [63:0] redir_target;
   bit force_redir;
   logic [63:0] force_pc;

   // Slave and model state
   bit sl_busy, ar_pending, ar_tainted, line_tainted, line_err;
   logic [63:0] sl_base, ar_hold, last_ar, mdl_fetch, exp_pc, first_pop_pc;
   int sl_beat, sl_err_beat, err_next;
   int ar_count, pops, beats, low_pops;

   function automatic logic [31:0] word(input logic [63:0] a);
      return a[31:0] ^ {a[15:0], 16'h0000} ^ 32'h9E37_79B9;
   endfunction

   task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task tick();
      logic [63:0] a;
      @(negedge clk);
      m_axi_arready = ($urandom_range(99) < p_arready);
      if (sl_busy && ($urandom_range(99) < p_rvalid)) begin
         a            = sl_base + 64'(8 * sl_beat);
         m_axi_rvalid = 1'b1;
         m_axi_rdata  = {word(a + 64'd4), word(a)};
         m_axi_rlast  = (sl_beat == 7);
         m_axi_rresp  = (sl_beat == sl_err_beat) ? 2'b10 : 2'b00;
      end else begin
         m_axi_rvalid = 1'b0;
         m_axi_rdata  = '0;
         m_axi_rlast  = 1'b0;
         m_axi_rresp  = 2'b00;
      end
      instr_ready    = (pop_budget != 0) && ($urandom_range(99) < p_ready);
      redirect_valid = 1'b0;
      if (force_redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = force_pc;
         force_redir    = 1'b0;
      end else if (redir_at_beat >= 0 && m_axi_rvalid && sl_beat == redir_at_beat) begin
         redirect_valid = 1'b1;
         redirect_pc    = redir_target;
         redir_at_beat  = -1;
      end else if (p_redir > 0 && $urandom_range(999) < p_redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = 64'h4000 + 64'(4 * $urandom_range(2047));
      end
      #1;
      chk("ar_while_busy", 64'(m_axi_arvalid && sl_busy), 64'd0);
      if (m_axi_rvalid) chk("rready", 64'(m_axi_rready), 64'd1);
      if (redirect_valid) chk("instr_valid_on_redirect", 64'(instr_valid), 64'd0);
      if (m_axi_arvalid) begin
         if (!ar_pending) begin
            ar_pending = 1'b1;
            ar_hold    = m_axi_araddr;
            chk("araddr", m_axi_araddr, mdl_fetch & ~64'd63);
            chk("arlen", 64'(m_axi_arlen), 64'd7);
            chk("arsize", 64'(m_axi_arsize), 64'd3);
            chk("arburst", 64'(m_axi_arburst), 64'd1);
            chk("arid", 64'(m_axi_arid), 64'd0);
            chk("arprot", 64'(m_axi_arprot), 64'd4);
         end else begin
            chk("araddr_stable", m_axi_araddr, ar_hold);
         end
      end
      if (m_axi_rvalid && m_axi_rready) begin
         beats++;
         if (m_axi_rresp != 2'b00) line_err = 1'b1;
         if (m_axi_rlast) begin
            sl_busy = 1'b0;
            if (!line_tainted && !line_err) mdl_fetch = sl_base + 64'd64;
         end else begin
            sl_beat++;
         end
      end
      if (m_axi_arvalid && m_axi_arready) begin
         ar_count++;
         last_ar      = m_axi_araddr;
         sl_busy      = 1'b1;
         sl_base      = m_axi_araddr;
         sl_beat      = 0;
         sl_err_beat  = err_next;
         err_next     = -1;
         ar_pending   = 1'b0;
         line_tainted = ar_tainted;
         ar_tainted   = 1'b0;
         line_err     = 1'b0;
      end
      if (instr_valid && instr_ready) begin
         if (pops == 0) first_pop_pc = instr_pc;
         if (instr_pc < 64'h1040) low_pops++;
         chk("instr_pc", instr_pc, exp_pc);
         chk("instr", 64'(instr), 64'(word(exp_pc)));
         exp_pc = exp_pc + 64'd4;
         pops++;
         if (pop_budget > 0) pop_budget--;
      end
      if (redirect_valid) begin
         exp_pc    = redirect_pc;
         mdl_fetch = redirect_pc;
         if (ar_pending) ar_tainted = 1'b1;
         if (sl_busy) line_tainted = 1'b1;
      end
   endtask

   task run(input int n);
      repeat (n) tick();
   endtask

   task wait_ar(input int n, input int max_cycles);
      for (int i = 0; i < max_cycles && ar_count < n; i++) tick();
      chk("ar_count_reached", 64'(ar_count), 64'(n));
   endtask

   task wait_pops(input int n, input int max_cycles);
      for (int i = 0; i < max_cycles && pops < n; i++) tick();
      chk("pops_reached", 64'(pops), 64'(n));
   endtask

   task do_reset(input logic [63:0] e);
      @(negedge clk);
      reset = 1'b1; entry = e;
      redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
      m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rid = '0;
      sl_busy = 0; ar_pending = 0; ar_tainted = 0; line_tainted = 0; line_err = 0;
      sl_beat = 0; sl_err_beat = -1; err_next = -1; sl_base = '0; ar_hold = '0;
      ar_count = 0; pops = 0; beats = 0; low_pops = 0; last_ar = '0; first_pop_pc = '0;
      exp_pc = e; mdl_fetch = e;
      redir_at_beat = -1; redir_target = '0; force_redir = 0; force_pc = '0;
      p_redir = 0; pop_budget = -1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
      chk("rst_rready", 64'(m_axi_rready), 64'd0);
      chk("rst_instr_valid", 64'(instr_valid), 64'd0);
      chk("rst_fetch_error", 64'(fetch_error), 64'd0);
      reset = 1'b0;
      #1;
      chk("no_ar_before_edge", 64'(m_axi_arvalid), 64'd0);
   endtask

   initial begin
      p_arready = 100; p_rvalid = 100; p_ready = 100; p_redir = 0; pop_budget = -1;

      // Aligned entry: full line in order, then next line
      do_reset(64'h1000);
      wait_ar(1, 20);
      chk("first_araddr", last_ar, 64'h1000);
      wait_pops(16, 200);
      wait_ar(2, 50);
      chk("second_araddr", last_ar, 64'h1040);

      // Mid-line entry: leading instructions of the first line discarded
      do_reset(64'h1024);
      wait_ar(1, 20);
      chk("mid_first_araddr", last_ar, 64'h1000);
      wait_ar(2, 60);
      chk("mid_second_araddr", last_ar, 64'h1040);
      run(40);
      chk("mid_first_pop_pc", first_pop_pc, 64'h1024);
      chk("mid_line1_pops", 64'(low_pops), 64'd7);

      // Stalled consumer: two lines fill the FIFO; a third AR needs 16 free entries
      do_reset(64'h1000);
      pop_budget = 0;
      run(100);
      chk("full_ar_count", 64'(ar_count), 64'd2);
      chk("full_arvalid", 64'(m_axi_arvalid), 64'd0);
      chk("full_instr_valid", 64'(instr_valid), 64'd1);
      pop_budget = 15;
      run(40);
      chk("pops_15", 64'(pops), 64'd15);
      chk("no_ar_at_15_free", 64'(ar_count), 64'd2);
      pop_budget = 1;
      wait_ar(3, 40);
      chk("third_araddr", last_ar, 64'h1080);
      pop_budget = -1;
      wait_pops(48, 300);

      // Redirect on beat 3: rest of the line drained, nothing kept
      do_reset(64'h1000);
      pop_budget = 0;
      redir_at_beat = 3; redir_target = 64'h2000;
      wait_ar(2, 100);
      chk("redir_beats_drained", 64'(beats), 64'd8);
      chk("redir_instr_valid", 64'(instr_valid), 64'd0);
      chk("redir_araddr", last_ar, 64'h2000);
      pop_budget = -1;
      wait_pops(16, 100);

      // Bus error on beat 2: four instructions kept, halt until redirect
      do_reset(64'h1000);
      err_next = 2;
      run(60);
      chk("err_fetch_error", 64'(fetch_error), 64'd1);
      chk("err_pops", 64'(pops), 64'd4);
      chk("err_ar_count", 64'(ar_count), 64'd1);
      chk("err_arvalid", 64'(m_axi_arvalid), 64'd0);
      chk("err_beats", 64'(beats), 64'd8);
      force_redir = 1'b1; force_pc = 64'h3000;
      run(2);
      chk("err_cleared", 64'(fetch_error), 64'd0);
      wait_ar(2, 20);
      chk("err_redir_araddr", last_ar, 64'h3000);
      wait_pops(20, 100);

      // Random traffic around a near-full FIFO, then with random redirects
      do_reset(64'h1000);
      p_arready = 60; p_rvalid = 70; pop_budget = 0;
      run(150);
      pop_budget = 1;
      run(5);
      pop_budget = -1; p_ready = 55;
      run(300);
      p_redir = 8;
      run(500);
      p_redir = 0;
      run(100);
      chk("random_progress", 64'(pops > 100), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
